// File: rtl/hw_pkg.sv
// Hardware-wide widths shared by the processing elements.
// Memory address and register tag sizes.
package hw_pkg;
    localparam int GLOBAL_MEM_ADDR_L = 32;
    localparam int REG_ADDR_L        = 5;
endpackage

// File: rtl/pe_pkg.sv
// Processing-element defaults and the load-stream FSM state type.
// Imported by ld_stream_unit.
package pe_pkg;
    localparam int LD_STREAM_CNT_L        = 8;
    localparam int LD_DATA_FIFO_DEPTH     = 8;
    localparam int MAX_OUTSTANDING_LD_REQ = 4;
    parameter  int LD_STALL_CNT_L         = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WAIT_WORD,
        ISSUE
    } ld_stream_state_t;
endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count and a combinational head.
// Push is accepted when not full, or when full with a pop in the same cycle.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_L = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [PTR_L-1:0] LAST = PTR_L'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_L-1:0] r_wr_ptr;
    logic [PTR_L-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap at DEPTH; count tracks accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// File: rtl/ld_stream_unit.sv
// Load-stream unit: fetches {addr,reg} words, issues credited reads, queues tagged data.
// Define LD_STREAM_PERF_CNT_EN to build the saturating memory stall counter.
module ld_stream_unit
    import pe_pkg::*;
#(
    parameter int ADDR_L          = hw_pkg::GLOBAL_MEM_ADDR_L,
    parameter int REG_ADDR_L      = hw_pkg::REG_ADDR_L,
    parameter int DATA_L          = 32,
    parameter int CNT_L           = LD_STREAM_CNT_L,
    parameter int FIFO_DEPTH      = LD_DATA_FIFO_DEPTH,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_LD_REQ
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         len_load,
    input  logic [CNT_L-1:0]             len_in,
    output logic                         stream_req,
    input  logic                         stream_gnt,
    input  logic [ADDR_L+REG_ADDR_L-1:0] stream_word,
    output logic                         mem_req,
    output logic [ADDR_L-1:0]            mem_addr,
    input  logic                         mem_gnt,
    input  logic                         mem_rd_vld,
    input  logic [DATA_L-1:0]            mem_rd_data,
    output logic                         out_vld,
    output logic [DATA_L-1:0]            out_data,
    output logic [REG_ADDR_L-1:0]        out_reg,
    input  logic                         pop,
    output logic                         busy,
    output logic [LD_STALL_CNT_L-1:0]    stall_cnt
);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W  = ((OUT_W > FCNT_W) ? OUT_W : FCNT_W) + 1;
    localparam int ENT_W  = DATA_L + REG_ADDR_L;

    ld_stream_state_t        r_state;
    ld_stream_state_t        w_state_nxt;
    logic [CNT_L-1:0]        r_remaining;
    logic [CNT_L-1:0]        w_remaining_nxt;
    logic [ADDR_L-1:0]       r_addr_q;
    logic [REG_ADDR_L-1:0]   r_reg_q;
    logic [OUT_W-1:0]        r_outstanding;
    logic                    w_grant;
    logic                    w_rsp;
    logic                    w_tag_empty;
    logic                    w_out_pop;
    logic [REG_ADDR_L-1:0]   w_rsp_tag;
    logic [OUT_W-1:0]        w_tag_cnt;
    logic [FCNT_W-1:0]       w_fifo_cnt;
    logic [ENT_W-1:0]        w_head;
    logic [SUM_W-1:0]        w_credit;

    // Entries already buffered plus reads in flight must fit in the data FIFO.
    assign w_credit = SUM_W'(w_fifo_cnt) + SUM_W'(r_outstanding);

    assign mem_req = (r_state == ISSUE)
                  && (r_outstanding < OUT_W'(MAX_OUTSTANDING))
                  && (w_credit < SUM_W'(FIFO_DEPTH));
    assign mem_addr = (r_state == ISSUE) ? r_addr_q : '0;

    assign w_grant     = mem_req && mem_gnt;
    assign w_tag_empty = (w_tag_cnt == '0);
    assign w_rsp       = mem_rd_vld && !w_tag_empty;

    assign out_vld   = (w_fifo_cnt != '0);
    assign w_out_pop = pop && out_vld;
    assign out_data  = w_head[ENT_W-1:REG_ADDR_L];
    assign out_reg   = w_head[REG_ADDR_L-1:0];

    assign busy = (r_state != IDLE) || (r_outstanding != '0);

    // Next-state and stream request decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        stream_req      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (len_load && (len_in != '0)) begin
                    w_state_nxt     = FETCH;
                    w_remaining_nxt = len_in;
                end
            end
            FETCH: begin
                stream_req = 1'b1;
                if (stream_gnt) begin
                    w_state_nxt = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
                if (w_grant) begin
                    w_remaining_nxt = r_remaining - 1'b1;
                    w_state_nxt = (r_remaining == CNT_L'(1)) ? IDLE : FETCH;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, remaining length and latched stream word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_addr_q    <= '0;
            r_reg_q     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            if (r_state == WAIT_WORD) begin
                r_addr_q <= stream_word[ADDR_L+REG_ADDR_L-1:REG_ADDR_L];
                r_reg_q  <= stream_word[REG_ADDR_L-1:0];
            end
        end
    end

    // In-flight read count; a grant and response together cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else if (w_grant && !w_rsp) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (w_rsp && !w_grant) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    fifo_sync #(
        .WIDTH (REG_ADDR_L),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_data  (r_reg_q),
        .i_pop   (w_rsp),
        .o_data  (w_rsp_tag),
        .o_count (w_tag_cnt)
    );

    fifo_sync #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_data_q (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp),
        .i_data  ({mem_rd_data, w_rsp_tag}),
        .i_pop   (w_out_pop),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

`ifdef LD_STREAM_PERF_CNT_EN
    logic [LD_STALL_CNT_L-1:0] r_stall_cnt;

    // Count cycles a read request waits for grant, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (mem_req && !mem_gnt && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ld_stream_unit.sv
// Directed bench for ld_stream_unit with a 1-cycle in-order memory model.
// Stall-count expectation follows LD_STREAM_PERF_CNT_EN.
module tb_ld_stream_unit;
    localparam int ADDR_L = 16;
    localparam int REG_L  = 5;
    localparam int DATA_L = 32;
    localparam int CNT_L  = 8;

`ifdef LD_STREAM_PERF_CNT_EN
    localparam int STALL_EXP = 10;
`else
    localparam int STALL_EXP = 0;
`endif

    logic                    clk;
    logic                    rst;
    logic                    len_load;
    logic [CNT_L-1:0]        len_in;
    logic                    stream_req;
    logic                    stream_gnt;
    logic [ADDR_L+REG_L-1:0] stream_word;
    logic                    mem_req;
    logic [ADDR_L-1:0]       mem_addr;
    logic                    mem_gnt;
    logic                    mem_rd_vld;
    logic [DATA_L-1:0]       mem_rd_data;
    logic                    out_vld;
    logic [DATA_L-1:0]       out_data;
    logic [REG_L-1:0]        out_reg;
    logic                    pop;
    logic                    busy;
    logic [15:0]             stall_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int n_gnt;
    int n_rsp;
    int sidx;
    logic rsp_en;
    logic seen_vld;
    logic [ADDR_L-1:0] mq [$];
    logic [ADDR_L-1:0] gaddr [$];
    logic [DATA_L+REG_L-1:0] pq [$];

    logic [ADDR_L-1:0] a_tab [8] = '{16'h1000, 16'h1004, 16'h2010, 16'h3FFC,
                                     16'h0008, 16'hBEEC, 16'h7770, 16'h0100};
    logic [REG_L-1:0]  r_tab [8] = '{5'd3, 5'd17, 5'd31, 5'd0,
                                     5'd9, 5'd22, 5'd1, 5'd14};

    ld_stream_unit #(
        .ADDR_L          (ADDR_L),
        .REG_ADDR_L      (REG_L),
        .DATA_L          (DATA_L),
        .CNT_L           (CNT_L),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .len_load    (len_load),
        .len_in      (len_in),
        .stream_req  (stream_req),
        .stream_gnt  (stream_gnt),
        .stream_word (stream_word),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rd_vld  (mem_rd_vld),
        .mem_rd_data (mem_rd_data),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_reg     (out_reg),
        .pop         (pop),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic sg;
        logic [ADDR_L-1:0] a;
        @(negedge clk);
        if (mem_req && mem_gnt) begin
            mq.push_back(mem_addr);
            gaddr.push_back(mem_addr);
            n_gnt++;
        end
        if (mem_rd_vld) n_rsp++;
        if (pop && out_vld) pq.push_back({out_data, out_reg});
        if (out_vld) seen_vld = 1'b1;
        sg = stream_req && stream_gnt;
        @(posedge clk);
        #1;
        if (sg) begin
            stream_word = {a_tab[sidx[2:0]], r_tab[sidx[2:0]]};
            sidx++;
        end
        if (rsp_en && mq.size() > 0) begin
            a = mq.pop_front();
            mem_rd_vld  = 1'b1;
            mem_rd_data = {16'hDA7A, a};
        end else begin
            mem_rd_vld  = 1'b0;
            mem_rd_data = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        len_load = 1'b0;
        len_in = '0;
        pop = 1'b0;
        mem_gnt = 1'b0;
        mem_rd_vld = 1'b0;
        mem_rd_data = '0;
        stream_word = '0;
        rsp_en = 1'b0;
        sidx = 0;
        n_gnt = 0;
        n_rsp = 0;
        seen_vld = 1'b0;
        mq.delete();
        gaddr.delete();
        pq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((busy || out_vld) && n < max) begin
            step();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic check_pops(input string tag, input int cnt);
        logic [DATA_L+REG_L-1:0] e;
        logic [DATA_L-1:0] ed;
        check({tag, "_n"}, pq.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            e = (i < pq.size()) ? pq[i] : '0;
            ed = {16'hDA7A, a_tab[i]};
            check($sformatf("%s_reg%0d", tag, i), e[REG_L-1:0], r_tab[i]);
            check($sformatf("%s_dat%0d", tag, i), e[DATA_L+REG_L-1:REG_L], ed);
        end
    endtask

    initial begin
        int n;
        stream_gnt = 1'b1;
        rst = 1'b1;
        len_load = 1'b0;
        len_in = '0;
        pop = 1'b0;
        mem_gnt = 1'b0;
        mem_rd_vld = 1'b0;
        mem_rd_data = '0;
        stream_word = '0;
        #3;
        check("A_sreq", stream_req, 0);
        check("A_mreq", mem_req, 0);
        check("A_maddr", mem_addr, 0);
        check("A_vld", out_vld, 0);
        check("A_data", out_data, 0);
        check("A_reg", out_reg, 0);
        check("A_busy", busy, 0);
        check("A_stall", stall_cnt, 0);

        do_reset();
        pop = 1'b1;
        mem_gnt = 1'b1;
        rsp_en = 1'b1;
        len_in = 8'd3;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        check("B_fetch", stream_req, 1);
        check("B_lat1", mem_req, 0);
        step();
        check("B_lat2", mem_req, 0);
        step();
        check("B_lat3", mem_req, 1);
        check("B_addr0", mem_addr, a_tab[0]);
        drain("B_done", 60);
        check("B_gnts", n_gnt, 3);
        check("B_rsps", n_rsp, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("B_gaddr%0d", i),
                  (i < gaddr.size()) ? gaddr[i] : 16'h0, a_tab[i]);
        end
        check_pops("B_pop", 3);

        do_reset();
        mem_gnt = 1'b1;
        rsp_en = 1'b1;
        len_in = 8'd6;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        repeat (40) step();
        check("C_gnt_cap", n_gnt, 4);
        check("C_req_low", mem_req, 0);
        check("C_vld", out_vld, 1);
        check("C_busy", busy, 1);
        pop = 1'b1;
        step();
        step();
        pop = 1'b0;
        repeat (40) step();
        check("C_gnt_more", n_gnt, 6);
        check("C_two_pops", pq.size(), 2);
        check("C_idle", busy, 0);
        pop = 1'b1;
        drain("C_done", 40);
        check_pops("C_pop", 6);

        do_reset();
        mem_gnt = 1'b1;
        rsp_en = 1'b0;
        pop = 1'b1;
        len_in = 8'd6;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        repeat (40) step();
        check("D_gnt_cap", n_gnt, 4);
        check("D_req_low", mem_req, 0);
        check("D_vld", out_vld, 0);
        rsp_en = 1'b1;
        step();
        check("D_hold", n_gnt, 4);
        check("D_req_wait", mem_req, 0);
        drain("D_done", 80);
        check("D_gnts", n_gnt, 6);
        check_pops("D_pop", 6);

        do_reset();
        mem_gnt = 1'b0;
        rsp_en = 1'b1;
        pop = 1'b1;
        len_in = 8'd3;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        check("E_issue", mem_req, 1);
        len_in = 8'd5;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        len_in = '0;
        repeat (9) step();
        check("E_stall", stall_cnt, STALL_EXP);
        mem_gnt = 1'b1;
        step();
        check("E_stall_hold", stall_cnt, STALL_EXP);
        drain("E_done", 60);
        check("E_gnts", n_gnt, 3);
        len_in = '0;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        check("E_zero_busy", busy, 0);
        check("E_zero_sreq", stream_req, 0);
        step();
        check("E_zero_busy2", busy, 0);

        do_reset();
        mem_gnt = 1'b1;
        rsp_en = 1'b0;
        pop = 1'b1;
        len_in = 8'd3;
        len_load = 1'b1;
        step();
        len_load = 1'b0;
        n = 0;
        while (n_gnt < 2 && n < 40) begin
            step();
            n++;
        end
        check("F_two_out", n_gnt, 2);
        check("F_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("F_sreq", stream_req, 0);
        check("F_mreq", mem_req, 0);
        check("F_maddr", mem_addr, 0);
        check("F_vld", out_vld, 0);
        check("F_data", out_data, 0);
        check("F_reg", out_reg, 0);
        check("F_busy", busy, 0);
        #2;
        rst = 1'b0;
        seen_vld = 1'b0;
        rsp_en = 1'b1;
        repeat (10) step();
        check("F_late_rsp", n_rsp >= 2, 1);
        check("F_late_vld", seen_vld, 0);
        check("F_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
